// File: rtl/ooo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ooo_pkg
// Purpose  : Shared widths and the reservation-station entry type.
// Revision : 1.0
// ============================================================================
package ooo_pkg;

  localparam int DEF_NSRC   = 2;
  localparam int DEF_TAG_W  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ROB_W  = 8;
  localparam int PAYLOAD_W  = 8;

  typedef struct packed {
    logic                                  valid;
    logic [PAYLOAD_W-1:0]                  operand;
    logic [PAYLOAD_W-1:0]                  wbs;
    logic [PAYLOAD_W-1:0]                  flags;
    logic [DEF_ROB_W-1:0]                  robid;
    logic [DEF_NSRC-1:0][DEF_TAG_W-1:0]    tag;
    logic [DEF_NSRC-1:0]                   rdy;
    logic [DEF_NSRC-1:0][DEF_DATA_W-1:0]   val;
  } rs_entry_t;

  function automatic logic entry_ready(input rs_entry_t e);
    return e.valid & (&e.rdy);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_bank.sv
`default_nettype none
// ============================================================================
// Module   : rs_bank
// Purpose  : One compacting reservation-station queue with oldest-ready select.
// Revision : 1.0
// ============================================================================
module rs_bank
  import ooo_pkg::*;
#(
  parameter int RS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           accept_i,
  input  rs_entry_t                      new_entry_i,
  input  logic                           cdb_valid_i,
  input  logic [DEF_TAG_W-1:0]           cdb_tag_i,
  input  logic [DEF_DATA_W-1:0]          cdb_val_i,
  input  logic                           fu_ready_i,
  output logic                           fu_valid_o,
  output logic [PAYLOAD_W-1:0]           fu_operand_o,
  output logic [PAYLOAD_W-1:0]           fu_wbs_o,
  output logic [PAYLOAD_W-1:0]           fu_flags_o,
  output logic [DEF_ROB_W-1:0]           fu_robid_o,
  output logic [DEF_NSRC*DEF_DATA_W-1:0] fu_srcval_o,
  output logic                           full_o,
  output logic [$clog2(RS_DEPTH+1)-1:0]  count_o
);

  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = $clog2(RS_DEPTH);

  rs_entry_t        entries_q [RS_DEPTH];
  rs_entry_t        entries_d [RS_DEPTH];
  rs_entry_t        w_woke    [RS_DEPTH+1];
  rs_entry_t        w_new;
  rs_entry_t        w_sel_entry;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] w_slot;
  logic [IDX_W-1:0] w_sel;
  logic             w_any_rdy;
  logic             w_dispatch;

  // Descending scan so the lowest ready index wins.
  always_comb begin
    w_sel     = '0;
    w_any_rdy = 1'b0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (entry_ready(entries_q[i])) begin
        w_sel     = IDX_W'(i);
        w_any_rdy = 1'b1;
      end
    end
  end

  assign w_sel_entry  = w_any_rdy ? entries_q[w_sel] : '0;
  assign w_dispatch   = w_any_rdy & fu_ready_i;
  assign fu_valid_o   = w_any_rdy;
  assign fu_operand_o = w_sel_entry.operand;
  assign fu_wbs_o     = w_sel_entry.wbs;
  assign fu_flags_o   = w_sel_entry.flags;
  assign fu_robid_o   = w_sel_entry.robid;
  assign fu_srcval_o  = w_sel_entry.val;
  assign full_o       = (count_q == CNT_W'(RS_DEPTH));
  assign count_o      = count_q;

  always_comb begin
    w_new = new_entry_i;
    for (int s = 0; s < DEF_NSRC; s++) begin
      if (!new_entry_i.rdy[s] && cdb_valid_i && new_entry_i.tag[s] == cdb_tag_i) begin
        w_new.rdy[s] = 1'b1;
        w_new.val[s] = cdb_val_i;
      end
    end

    for (int i = 0; i < RS_DEPTH; i++) begin
      w_woke[i] = entries_q[i];
      for (int s = 0; s < DEF_NSRC; s++) begin
        if (entries_q[i].valid && !entries_q[i].rdy[s] && cdb_valid_i &&
            entries_q[i].tag[s] == cdb_tag_i) begin
          w_woke[i].rdy[s] = 1'b1;
          w_woke[i].val[s] = cdb_val_i;
        end
      end
    end
    w_woke[RS_DEPTH] = '0;

    // A same-cycle dispatch frees one slot below the tail, so the new entry lands there.
    w_slot = count_q - CNT_W'(w_dispatch);
    for (int i = 0; i < RS_DEPTH; i++) begin
      entries_d[i] = (w_dispatch && i >= int'(w_sel)) ? w_woke[i+1] : w_woke[i];
      if (accept_i && w_slot == CNT_W'(i)) begin
        entries_d[i] = w_new;
      end
    end
    count_d = count_q + CNT_W'(accept_i) - CNT_W'(w_dispatch);

    if (flush_i) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_d[i] = '0;
      end
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue
// Purpose  : Per-FU reservation-station array: bank decode, in_ready mux, CDB fan-out.
// Revision : 1.0
// ============================================================================
module issue_queue
  import ooo_pkg::*;
#(
  parameter int FU_COUNT = 8,
  parameter int RS_DEPTH = 4,
  parameter int NSRC     = DEF_NSRC,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ROB_W    = DEF_ROB_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [$clog2(FU_COUNT)-1:0]             in_fu,
  input  logic [NSRC*TAG_W-1:0]                   in_tag,
  input  logic [NSRC-1:0]                         in_src_rdy,
  input  logic [NSRC*DATA_W-1:0]                  in_src_val,
  input  logic [7:0]                              in_operand,
  input  logic [7:0]                              in_wbs,
  input  logic [7:0]                              in_flags,
  input  logic [ROB_W-1:0]                        in_robid,
  input  logic                                    cdb_valid,
  input  logic [TAG_W-1:0]                        cdb_tag,
  input  logic [DATA_W-1:0]                       cdb_val,
  input  logic                                    flush,
  output logic [FU_COUNT-1:0]                     fu_valid,
  input  logic [FU_COUNT-1:0]                     fu_ready,
  output logic [FU_COUNT*8-1:0]                   fu_operand,
  output logic [FU_COUNT*8-1:0]                   fu_wbs,
  output logic [FU_COUNT*8-1:0]                   fu_flags,
  output logic [FU_COUNT*ROB_W-1:0]               fu_robid,
  output logic [FU_COUNT*NSRC*DATA_W-1:0]         fu_srcval,
  output logic [FU_COUNT*$clog2(RS_DEPTH+1)-1:0]  bank_count
);

  localparam int FU_W  = $clog2(FU_COUNT);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int SV_W  = NSRC * DATA_W;

  rs_entry_t           w_new;
  logic [FU_COUNT-1:0] w_full;
  logic                w_target_full;

  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.operand = in_operand;
    w_new.wbs     = in_wbs;
    w_new.flags   = in_flags;
    w_new.robid   = in_robid;
    w_new.tag     = in_tag;
    w_new.rdy     = in_src_rdy;
    w_new.val     = in_src_val;
  end

  // An in_fu outside the populated banks reads as full.
  always_comb begin
    w_target_full = 1'b1;
    for (int f = 0; f < FU_COUNT; f++) begin
      if (in_fu == FU_W'(f)) begin
        w_target_full = w_full[f];
      end
    end
  end

  assign in_ready = ~flush & ~w_target_full;

  for (genvar f = 0; f < FU_COUNT; f++) begin : g_bank
    rs_bank #(
      .RS_DEPTH (RS_DEPTH)
    ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .accept_i     (in_valid & in_ready & (in_fu == FU_W'(f))),
      .new_entry_i  (w_new),
      .cdb_valid_i  (cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_val_i    (cdb_val),
      .fu_ready_i   (fu_ready[f]),
      .fu_valid_o   (fu_valid[f]),
      .fu_operand_o (fu_operand[f*8 +: 8]),
      .fu_wbs_o     (fu_wbs[f*8 +: 8]),
      .fu_flags_o   (fu_flags[f*8 +: 8]),
      .fu_robid_o   (fu_robid[f*ROB_W +: ROB_W]),
      .fu_srcval_o  (fu_srcval[f*SV_W +: SV_W]),
      .full_o       (w_full[f]),
      .count_o      (bank_count[f*CNT_W +: CNT_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_queue
// Purpose  : Directed scoreboard bench for issue_queue (8 banks x 4 entries).
// Revision : 1.0
// ============================================================================
module tb_issue_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_fu;
  logic [7:0]   in_tag;
  logic [1:0]   in_src_rdy;
  logic [15:0]  in_src_val;
  logic [7:0]   in_operand, in_wbs, in_flags, in_robid;
  logic         cdb_valid;
  logic [3:0]   cdb_tag;
  logic [7:0]   cdb_val;
  logic         flush;
  logic [7:0]   fu_valid;
  logic [7:0]   fu_ready;
  logic [63:0]  fu_operand, fu_wbs, fu_flags, fu_robid;
  logic [127:0] fu_srcval;
  logic [23:0]  bank_count;

  typedef struct packed {
    logic [2:0]  fu;
    logic [7:0]  rob;
    logic [15:0] sv;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] exp_op, exp_wbs, exp_fl;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  issue_queue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fu      (in_fu),
    .in_tag     (in_tag),
    .in_src_rdy (in_src_rdy),
    .in_src_val (in_src_val),
    .in_operand (in_operand),
    .in_wbs     (in_wbs),
    .in_flags   (in_flags),
    .in_robid   (in_robid),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_val    (cdb_val),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_ready   (fu_ready),
    .fu_operand (fu_operand),
    .fu_wbs     (fu_wbs),
    .fu_flags   (fu_flags),
    .fu_robid   (fu_robid),
    .fu_srcval  (fu_srcval),
    .bank_count (bank_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] cnt(input int f);
    return bank_count[f*3 +: 3];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] fu, input logic [7:0] rob,
                       input logic [3:0] t0, input logic [3:0] t1, input logic [1:0] rdy,
                       input logic [7:0] v0, input logic [7:0] v1);
    in_valid   = 1'b1;
    in_fu      = fu;
    in_robid   = rob;
    in_tag     = {t1, t0};
    in_src_rdy = rdy;
    in_src_val = {v1, v0};
    in_operand = rob ^ 8'h5A;
    in_wbs     = rob + 8'd1;
    in_flags   = ~rob;
  endtask

  task automatic expect_disp(input logic [2:0] fu, input logic [7:0] rob, input logic [15:0] sv);
    exp_t e;
    e.fu  = fu;
    e.rob = rob;
    e.sv  = sv;
    sb.push_back(e);
  endtask

  // Monitor: every handshake the DUT completes must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst) begin
      for (int f = 0; f < 8; f++) begin
        if (fu_valid[f] && fu_ready[f]) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_dispatch: fu=%0d robid=%0h, no dispatch required", f, fu_robid[f*8 +: 8]);
          end else begin
            mon_e   = sb.pop_front();
            exp_op  = mon_e.rob ^ 8'h5A;
            exp_wbs = mon_e.rob + 8'd1;
            exp_fl  = ~mon_e.rob;
            chk("disp_fu",      64'(f),                 64'(mon_e.fu));
            chk("disp_robid",   fu_robid[f*8 +: 8],     mon_e.rob);
            chk("disp_srcval",  fu_srcval[f*16 +: 16],  mon_e.sv);
            chk("disp_operand", fu_operand[f*8 +: 8],   exp_op);
            chk("disp_wbs",     fu_wbs[f*8 +: 8],       exp_wbs);
            chk("disp_flags",   fu_flags[f*8 +: 8],     exp_fl);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_fu = '0; in_tag = '0; in_src_rdy = '0;
    in_src_val = '0; in_operand = '0; in_wbs = '0; in_flags = '0; in_robid = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; flush = 1'b0; fu_ready = '0;

    tick; tick;
    chk("rst_fu_valid",   64'(fu_valid),   64'h0);
    chk("rst_bank_count", 64'(bank_count), 64'h0);
    chk("rst_srcval",     fu_srcval[63:0], 64'h0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // Both sources ready at issue.
    fu_ready = 8'h04;
    issue(3'd2, 8'h10, 4'd0, 4'd0, 2'b11, 8'h11, 8'h22);
    expect_disp(3'd2, 8'h10, 16'h2211);
    tick; idle;
    chk("t1_fu_valid", 64'(fu_valid), 64'h04);
    chk("t1_count",    64'(cnt(2)),   64'd1);
    chk("t1_idle_payload_zero", {8'h0, fu_operand[63:24], fu_operand[15:0]}, 64'h0);
    tick;
    chk("t1_count_after",    64'(cnt(2)),   64'd0);
    chk("t1_fu_valid_after", 64'(fu_valid), 64'h0);

    // Source 0 waits on tag 5, woken by a later broadcast.
    fu_ready = 8'h08;
    issue(3'd3, 8'h20, 4'd5, 4'd0, 2'b10, 8'h00, 8'h33);
    expect_disp(3'd3, 8'h20, 16'h33A5);
    tick; idle;
    chk("t2_wait0",  64'(fu_valid), 64'h0);
    chk("t2_count",  64'(cnt(3)),   64'd1);
    tick;
    chk("t2_wait1",  64'(fu_valid), 64'h0);
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_val = 8'hA5;
    tick; idle;
    chk("t2_woken",  64'(fu_valid), 64'h08);
    tick;
    chk("t2_count_after", 64'(cnt(3)), 64'd0);

    // Same-cycle CDB capture, both sources on tag 3.
    fu_ready = 8'h02;
    issue(3'd1, 8'h30, 4'd3, 4'd3, 2'b00, 8'h00, 8'h00);
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_val = 8'h3C;
    expect_disp(3'd1, 8'h30, 16'h3C3C);
    tick; idle;
    chk("t3_captured", 64'(fu_valid), 64'h02);
    tick;
    chk("t3_count_after", 64'(cnt(1)), 64'd0);

    // Fill bank 0, then release in order.
    fu_ready = 8'h00;
    for (int k = 0; k < 4; k++) begin
      issue(3'd0, 8'h40 + 8'(k), 4'd0, 4'd0, 2'b11, 8'h40 + 8'(k), 8'hC0 + 8'(k));
      expect_disp(3'd0, 8'h40 + 8'(k), {8'hC0 + 8'(k), 8'h40 + 8'(k)});
      #1;
      chk("t4_in_ready_fill", 64'(in_ready), 64'h1);
      tick;
    end
    idle;
    in_fu = 3'd0;
    #1;
    chk("t4_full_ready", 64'(in_ready), 64'h0);
    chk("t4_full_count", 64'(cnt(0)),   64'd4);
    fu_ready = 8'h01;
    #1;
    chk("t4_full_disp_ready", 64'(in_ready), 64'h0);
    in_fu = 3'd1;
    #1;
    chk("t4_other_ready", 64'(in_ready), 64'h1);
    in_fu = 3'd0;
    repeat (4) tick;
    chk("t4_drained", 64'(cnt(0)), 64'd0);
    fu_ready = 8'h00;

    // Out-of-order readiness plus accept during dispatch.
    issue(3'd4, 8'h50, 4'd0, 4'd0, 2'b11, 8'h01, 8'h02);
    expect_disp(3'd4, 8'h50, 16'h0201);
    tick;
    issue(3'd4, 8'h51, 4'd7, 4'd0, 2'b10, 8'h00, 8'h04);
    tick;
    issue(3'd4, 8'h52, 4'd0, 4'd0, 2'b11, 8'h05, 8'h06);
    expect_disp(3'd4, 8'h52, 16'h0605);
    tick;
    fu_ready = 8'h10;
    issue(3'd4, 8'h53, 4'd0, 4'd0, 2'b11, 8'h07, 8'h08);
    expect_disp(3'd4, 8'h53, 16'h0807);
    #1;
    chk("t5_sel_valid", 64'(fu_valid), 64'h10);
    tick; idle;
    chk("t5_count_3", 64'(cnt(4)), 64'd3);
    tick; tick;
    chk("t5_count_1",   64'(cnt(4)),   64'd1);
    chk("t5_idle_wait", 64'(fu_valid), 64'h0);
    expect_disp(3'd4, 8'h51, 16'h0477);
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_val = 8'h77;
    tick; idle;
    chk("t5_woken", 64'(fu_valid), 64'h10);
    tick;
    chk("t5_count_0", 64'(cnt(4)), 64'd0);
    fu_ready = 8'h00;

    // Flush with entries in two banks.
    issue(3'd5, 8'h60, 4'd0, 4'd0, 2'b11, 8'h61, 8'h62); tick;
    issue(3'd5, 8'h61, 4'd0, 4'd0, 2'b11, 8'h63, 8'h64); tick;
    issue(3'd6, 8'h62, 4'd9, 4'd0, 2'b10, 8'h00, 8'h66); tick;
    idle;
    chk("t6_count5", 64'(cnt(5)),   64'd2);
    chk("t6_count6", 64'(cnt(6)),   64'd1);
    chk("t6_valid",  64'(fu_valid), 64'h20);
    flush = 1'b1;
    issue(3'd6, 8'h63, 4'd0, 4'd0, 2'b11, 8'h01, 8'h01);
    #1;
    chk("t6_flush_ready", 64'(in_ready), 64'h0);
    tick; idle;
    flush = 1'b0;
    chk("t6_flushed_count", 64'(bank_count), 64'h0);
    chk("t6_flushed_valid", 64'(fu_valid),   64'h0);
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_val = 8'h99;
    tick; idle;
    chk("t6_no_ghost_wakeup", 64'(fu_valid), 64'h0);

    // Asynchronous reset in the middle of a wakeup.
    issue(3'd7, 8'h70, 4'hA, 4'd0, 2'b10, 8'h00, 8'h77);
    tick; idle;
    chk("t7_count", 64'(cnt(7)), 64'd1);
    cdb_valid = 1'b1; cdb_tag = 4'hA; cdb_val = 8'hAA;
    #2;
    rst = 1'b0;
    #1;
    chk("t7_async_count", 64'(bank_count), 64'h0);
    chk("t7_async_valid", 64'(fu_valid),   64'h0);
    tick; idle;
    rst = 1'b1;
    tick;
    chk("t7_post_count", 64'(bank_count), 64'h0);
    chk("t7_post_valid", 64'(fu_valid),   64'h0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_queue.md
# issue_queue

Parametrised reservation-station array for the out-of-order core, successor to the fixed 8×4 issue stage. It accepts one renamed instruction per cycle over a valid/ready handshake and buffers it in the per-FU bank named by the instruction. Source operands are captured from the register-file snapshot or by CDB wakeup. Each cycle it dispatches the oldest fully-ready entry of every bank to its FU over a per-FU valid/ready handshake, and it supports a full flush.

## Interface
- FU_COUNT, 8, number of functional units / banks
- RS_DEPTH, 4, entries per bank (≥2)
- NSRC, 2, source operands per instruction
- TAG_W, 4, physical-register tag width
- DATA_W, 8, operand/value width
- ROB_W, 8, ROB id width

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  bank in_fu has a free entry and flush=0
- in_fu  in  $clog2(FU_COUNT)  target bank
- in_tag  in  NSRC×TAG_W  source tags
- in_src_rdy  in  NSRC  source value already in register file
- in_src_val  in  NSRC×DATA_W  source values, meaningful where in_src_rdy=1
- in_operand, in_wbs, in_flags  in  8 each  opaque payload
- in_robid  in  ROB_W  ROB id
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_val  in  DATA_W  broadcast value
- flush  in  1  discard all entries
- fu_valid  out  FU_COUNT  dispatch offered per FU
- fu_ready  in  FU_COUNT  FU accepts
- fu_operand, fu_wbs, fu_flags  out  FU_COUNT×8  dispatched payload
- fu_robid  out  FU_COUNT×ROB_W  dispatched ROB id
- fu_srcval  out  FU_COUNT×NSRC×DATA_W  dispatched source values
- bank_count  out  FU_COUNT×$clog2(RS_DEPTH+1)  occupied entries per bank

## Operation
- Each bank is a compacting queue: entries 0..count-1 valid, index 0 oldest.
- Per-source state per entry: tag, rdy, val. An entry is ready when all NSRC rdy bits are set.
- Accept = in_valid & in_ready. The new entry goes to slot count, or count-1 if the same bank dispatches in that cycle.
- Capture on accept: per source, rdy = in_src_rdy | (cdb_valid & cdb_tag==in_tag). The value comes from in_src_val if in_src_rdy, else cdb_val.
- Wakeup: every valid entry with a not-ready source whose tag equals cdb_tag, while cdb_valid=1, sets rdy and latches cdb_val. All banks and all sources are checked in parallel, including duplicate tags within one entry.
- Select: fu_valid[f] = some ready entry in bank f. Payload is taken from the lowest-index ready entry and is combinational from registered state.
- Dispatch = fu_valid & fu_ready. The selected entry is removed and higher entries shift down one slot, with wakeups applied in the same edge.
- in_ready=0 when the target bank is full, even if it dispatches that cycle. No same-cycle full bypass.
- Flush: at the edge with flush=1, all banks are emptied and no accept occurs (in_ready=0). Dispatch handshakes in that cycle still complete at the FU. The queue drops them as part of the flush.
- Reset (rst=0): all entries invalid, counts 0. Outputs: fu_valid=0, payloads 0, bank_count=0, in_ready=1 once rst=1 and flush=0.
- Non-dispatching FUs drive all-zero payloads.

## Timing
- Accept at edge t with all sources ready → fu_valid at cycle t+1 earliest.
- CDB match in cycle t → entry dispatchable in cycle t+1, and fu_srcval carries the CDB value.
- Throughput: one accept and one dispatch per bank per cycle.
- bank_count is registered and reflects the edge's accept and dispatch.
- in_ready and fu_valid are combinational from state plus in_fu and flush. No combinational path from fu_ready to in_ready.

## Structure
- Package ooo_pkg: TAG_W/DATA_W/ROB_W defaults and an rs_entry_t struct (valid, payload, robid, src tag/rdy/val arrays).
- Sub-module rs_bank: one compacting queue with select, instantiated FU_COUNT times. issue_queue holds only bank decode, the in_ready mux and the CDB fan-out.

## Test plan
- After reset, issue to FU2 with in_src_rdy=2'b11 and values 0x11/0x22, fu_ready[2]=1 → fu_valid[2] next cycle with fu_srcval 0x11/0x22. bank_count[2] goes 1 then 0.
- Issue with tag 5 not ready, then cdb_valid with tag 5 and value 0xA5 two cycles later → fu_valid on the cycle after the broadcast, with srcval 0xA5.
- CDB broadcast of tag 3 in the same cycle as issuing an entry waiting on tag 3 → captured, and dispatches the next cycle.
- Fill FU0 with RS_DEPTH entries while fu_ready=0 → in_ready=0 for in_fu=0 and 1 for in_fu=1. Entries dispatch oldest-first by robid once released.
- Entries at indices 0 and 2 ready, 1 not ready → index 0 dispatches, then index 2. Simultaneous accept lands at the correct slot, verified by robid order.
- Flush with 3 entries in two banks → all bank_count=0 next cycle, no fu_valid. Asserting rst mid-wakeup clears state immediately.
